logic_shift_ctrl: RTL and testbench

Multi-cycle sequencer for the 32-bit logic/shift datapath. It accepts one operation per start pulse and computes bitwise ops in a single pass through the shared 32-bit AND/OR arrays. Shifts are computed serially, one bit position per clock, under a down-counter. It sits between the ALU operation decoder and the result mux and reports completion with a one-cycle done pulse.

---
 rtl/logic_shift_ctrl_pkg.sv | 39 +++
 rtl/and_array_32.sv | 20 ++
 rtl/or_array_32.sv | 20 ++
 rtl/shift1_32.sv | 23 ++
 rtl/logic_shift_ctrl.sv | 151 +++++++++++++++
 tb/tb_logic_shift_ctrl.sv | 195 +++++++++++++++++++
 6 files changed

// File: rtl/logic_shift_ctrl_pkg.sv
// ============================================================================
// Module      : logic_shift_ctrl_pkg
// Description : Op codes, state encodings and width defaults for the
//               logic/shift sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package logic_shift_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_CNT_W = 5;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_NOR = 3'b010;
    localparam logic [2:0] OP_SLL = 3'b100;
    localparam logic [2:0] OP_SRL = 3'b101;
    localparam logic [2:0] OP_SRA = 3'b110;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOGIC = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = S_IDLE,
        ST_LOGIC = S_LOGIC,
        ST_SHIFT = S_SHIFT,
        ST_DONE  = S_DONE
    } state_t;

    function automatic logic is_shift(input logic [2:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

`default_nettype wire

// File: rtl/and_array_32.sv
// ============================================================================
// Module      : and_array_32
// Description : 32-bit bitwise AND array.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module and_array_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);

    for (genvar i = 0; i < 32; i++) begin : g_bit
        assign y[i] = a[i] & b[i];
    end

endmodule

`default_nettype wire

// File: rtl/or_array_32.sv
// ============================================================================
// Module      : or_array_32
// Description : 32-bit bitwise OR array.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module or_array_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);

    for (genvar i = 0; i < 32; i++) begin : g_bit
        assign y[i] = a[i] | b[i];
    end

endmodule

`default_nettype wire

// File: rtl/shift1_32.sv
// ============================================================================
// Module      : shift1_32
// Description : Combinational one-position shifter (left, logical right or
//               arithmetic right).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift1_32 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] din,
    input  logic             dir,    // 1 = left
    input  logic             arith,  // right shifts only: replicate the MSB
    output logic [WIDTH-1:0] dout
);

    assign dout = dir ? {din[WIDTH-2:0], 1'b0}
                      : {arith & din[WIDTH-1], din[WIDTH-1:1]};

endmodule

`default_nettype wire

// File: rtl/logic_shift_ctrl.sv
// ============================================================================
// Module      : logic_shift_ctrl
// Description : Multi-cycle sequencer for the 32-bit logic/shift datapath;
//               single-pass logic ops, serial shifts, one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module logic_shift_ctrl
    import logic_shift_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done
);

    state_t           r_state;
    state_t           w_next;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_result;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] w_and;
    logic [WIDTH-1:0] w_or;
    logic [WIDTH-1:0] w_logic;
    logic [WIDTH-1:0] w_shifted;
    logic [CNT_W-1:0] w_shamt;

    assign w_shamt = num2[CNT_W-1:0];
    assign result  = r_result;

    and_array_32 u_and (
        .a (r_a),
        .b (r_b),
        .y (w_and)
    );

    or_array_32 u_or (
        .a (r_a),
        .b (r_b),
        .y (w_or)
    );

    shift1_32 #(
        .WIDTH (WIDTH)
    ) u_shift (
        .din   (r_acc),
        .dir   (r_op == OP_SLL),
        .arith (r_op == OP_SRA),
        .dout  (w_shifted)
    );

    // Illegal codes fall through to zero.
    always_comb begin
        w_logic = '0;
        case (r_op)
            OP_AND:  w_logic = w_and;
            OP_OR:   w_logic = w_or;
            OP_NOR:  w_logic = ~w_or;
            default: w_logic = '0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (!is_shift(op))
                        w_next = ST_LOGIC;
                    else if (w_shamt == '0)
                        w_next = ST_DONE;
                    else
                        w_next = ST_SHIFT;
                end
            end
            ST_LOGIC: begin
                busy   = 1'b1;
                w_next = ST_DONE;
            end
            ST_SHIFT: begin
                busy = 1'b1;
                if (r_cnt == CNT_W'(1))
                    w_next = ST_DONE;
            end
            ST_DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_cnt    <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_op <= op;
                        r_a  <= num1;
                        r_b  <= num2;
                        if (is_shift(op)) begin
                            if (w_shamt == '0) begin
                                r_result <= num1;
                            end else begin
                                r_acc <= num1;
                                r_cnt <= w_shamt;
                            end
                        end
                    end
                end
                ST_LOGIC: r_result <= w_logic;
                ST_SHIFT: begin
                    r_acc <= w_shifted;
                    r_cnt <= r_cnt - CNT_W'(1);
                    // Only the final shift position is ever published.
                    if (r_cnt == CNT_W'(1))
                        r_result <= w_shifted;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_logic_shift_ctrl.sv
// ============================================================================
// Module      : tb_logic_shift_ctrl
// Description : Directed and random self-checking bench for logic_shift_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_logic_shift_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] num1;
    logic [31:0] num2;
    logic [31:0] result;
    logic        busy;
    logic        done;

    int n_vec = 0;
    int n_err = 0;

    logic_shift_ctrl dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .num1   (num1),
        .num2   (num2),
        .result (result),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain arithmetic on the operation definitions.
    function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
        int unsigned s;
        logic signed [31:0] sa;
        s  = b & 32'd31;
        sa = a;
        case (o)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return ~(a | b);
            3'd4:    return a << s;
            3'd5:    return a >> s;
            3'd6:    return sa >>> s;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] o, input logic [31:0] b);
        int unsigned s;
        s = b & 32'd31;
        if (o == 3'd4 || o == 3'd5 || o == 3'd6)
            return (s == 0) ? 1 : int'(s) + 1;
        return 2;
    endfunction

    // Starts one op from IDLE (#1 after an edge) and checks latency, result,
    // result stability before completion and the return to IDLE.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b);
        logic [31:0] exp_res;
        logic [31:0] prev;
        int          lat;
        int          cyc;
        int          early;
        exp_res = ref_result(o, a, b);
        lat     = ref_latency(o, b);
        prev    = result;
        early   = 0;
        op = o; num1 = a; num2 = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        num1  = $urandom;
        num2  = $urandom;
        cyc   = 1;
        check({tag, " busy@1"}, {31'd0, busy}, 32'd1);
        while (!done && cyc < 40) begin
            if (result !== prev) early++;
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, " latency"}, cyc, lat);
        check({tag, " result"}, result, exp_res);
        check({tag, " early result change"}, early, 32'd0);
        @(posedge clk); #1;
        check({tag, " done cleared"}, {31'd0, done}, 32'd0);
        check({tag, " busy cleared"}, {31'd0, busy}, 32'd0);
        check({tag, " result held"}, result, exp_res);
    endtask

    initial begin
        int seen;
        rst = 1'b1; start = 1'b0; op = 3'd0; num1 = 32'd0; num2 = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset result", result, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("OR",  3'b001, 32'hF0F0_00FF, 32'h0FF0_F00F);
        check("OR const", result, 32'hFFF0_F0FF);
        run_op("AND", 3'b000, 32'hF0F0_00FF, 32'h0FF0_F00F);
        check("AND const", result, 32'h00F0_000F);
        run_op("NOR", 3'b010, 32'hF0F0_00FF, 32'h0FF0_F00F);
        check("NOR const", result, 32'h000F_0F00);

        run_op("SRA4", 3'b110, 32'h8000_0001, 32'd4);
        check("SRA4 const", result, 32'hF800_0000);
        run_op("SRL4", 3'b101, 32'h8000_0001, 32'd4);
        check("SRL4 const", result, 32'h0800_0000);
        run_op("SLL4", 3'b100, 32'h8000_0001, 32'd4);
        check("SLL4 const", result, 32'h0000_0010);

        run_op("SLL0",  3'b100, 32'h1234_5678, 32'd0);
        run_op("SRL31", 3'b101, 32'hFFFF_FFFF, 32'd31);
        check("SRL31 const", result, 32'h0000_0001);
        run_op("SLL hi bits", 3'b100, 32'd1, 32'hFFFF_FFE3);
        check("SLL hi bits const", result, 32'h0000_0008);

        // Reset in the middle of a 20-position shift.
        op = 3'b100; num1 = 32'd1; num2 = 32'd20; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midreset busy", {31'd0, busy}, 32'd0);
        check("midreset result", result, 32'd0);
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            if (done) seen++;
            @(posedge clk); #1;
        end
        check("midreset no done", seen, 32'd0);

        // Starts while busy are dropped; a start in IDLE right after is taken.
        op = 3'b000; num1 = 32'hF0F0_00FF; num2 = 32'h0FF0_F00F; start = 1'b1;
        @(posedge clk); #1;
        op = 3'b001; num1 = 32'h1234_5678; num2 = 32'h0F0F_0F0F;
        check("rej busy@1", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        check("rej done@2", {31'd0, done}, 32'd1);
        check("rej result@2", result, 32'h00F0_000F);
        @(posedge clk); #1;
        check("rej done@3", {31'd0, done}, 32'd0);
        check("rej busy@3", {31'd0, busy}, 32'd0);
        check("rej result@3", result, 32'h00F0_000F);
        @(posedge clk); #1;
        start = 1'b0;
        check("rej done@4", {31'd0, done}, 32'd0);
        check("rej busy@4", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        check("rej done@5", {31'd0, done}, 32'd1);
        check("rej result@5", result, 32'h1F3F_5F7F);
        @(posedge clk); #1;
        check("rej done@6", {31'd0, done}, 32'd0);

        run_op("ILL011", 3'b011, 32'hDEAD_BEEF, 32'hCAFE_F00D);
        run_op("ILL111", 3'b111, 32'h1357_9BDF, 32'hFFFF_FFFF);

        for (int k = 0; k < 60; k++) begin
            logic [2:0]  ro;
            logic [31:0] ra;
            logic [31:0] rb;
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            run_op("RAND", ro, ra, rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
